rsp_s2_prep_ahbic_error_slave: RTL and testbench

Parametrised default/error slave for the rsp_s2_prep AHB interconnect. It answers every transfer that decodes to no real slave, with a configurable number of wait states and a selectable response mode (two-cycle ERROR, or OKAY with fixed read data). It also logs the first faulting access and counts all faulting accesses for software, raising a level interrupt. It sits on the interconnect's default-decode port.

---
 rtl/rsp_s2_prep_ahbic_pkg.sv | 28 ++
 rtl/rsp_s2_prep_ahbic_error_slave_if.sv | 26 ++
 rtl/rsp_s2_prep_ahbic_err_log.sv | 52 +++++
 rtl/rsp_s2_prep_ahbic_error_slave.sv | 100 ++++++++++
 tb/tb_rsp_s2_prep_ahbic_error_slave.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsp_s2_prep_ahbic_pkg.sv
// rtl/rsp_s2_prep_ahbic_pkg.sv - shared AHB codes and error-slave FSM encoding
package rsp_s2_prep_ahbic_pkg;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } err_state_e;

    // NONSEQ and SEQ are the only transfer types that demand a response.
    function automatic logic trans_active(logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/rsp_s2_prep_ahbic_error_slave_if.sv
// rtl/rsp_s2_prep_ahbic_error_slave_if.sv - AHB default-slave port bundle
// master: drives HSEL/HADDR/HTRANS/HWRITE/HREADY, receives HREADYOUT/HRESP/HRDATA
// slave:  the reverse
interface rsp_s2_prep_ahbic_error_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/rsp_s2_prep_ahbic_err_log.sv
// rtl/rsp_s2_prep_ahbic_err_log.sv - first-fault capture and saturating fault counter
// HCLK/HRESETn: clock, synchronous active-low reset
// accept, HADDR, HWRITE: faulting access qualifier and its address-phase info
// err_clr: single-cycle clear of the log
// err_valid/err_addr/err_write: first fault since clear; err_count: saturating total
module rsp_s2_prep_ahbic_err_log #(
    parameter int ADDR_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     accept,
    input  logic [ADDR_WIDTH-1:0]    HADDR,
    input  logic                     HWRITE,
    input  logic                     err_clr,
    output logic                     err_valid,
    output logic [ADDR_WIDTH-1:0]    err_addr,
    output logic                     err_write,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    // A clear in the same cycle as a fault makes that fault the new "first" one.
    logic capture;
    assign capture = accept && (!err_valid || err_clr);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_write <= 1'b0;
            err_count <= '0;
        end else begin
            if (capture) begin
                err_addr  <= HADDR;
                err_write <= HWRITE;
            end

            if (accept) begin
                err_valid <= 1'b1;
            end else if (err_clr) begin
                err_valid <= 1'b0;
            end

            if (err_clr) begin
                err_count <= accept ? ERR_CNT_WIDTH'(1) : '0;
            end else if (accept && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/rsp_s2_prep_ahbic_error_slave.sv
// rtl/rsp_s2_prep_ahbic_error_slave.sv - AHB default/error slave with wait states and fault log
// HCLK/HRESETn: clock, synchronous active-low reset
// ahb: slave side of the default-decode port
// err_clr: clears the fault log; err_*: first-fault log, fault count, level interrupt
module rsp_s2_prep_ahbic_error_slave
    import rsp_s2_prep_ahbic_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    WAIT_STATES   = 0,
    parameter int                    RESP_MODE     = 1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = '0,
    parameter int                    ERR_CNT_WIDTH = 8
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    rsp_s2_prep_ahbic_error_slave_if.slave    ahb,
    input  logic                              err_clr,
    output logic                              err_valid,
    output logic [ADDR_WIDTH-1:0]             err_addr,
    output logic                              err_write,
    output logic [ERR_CNT_WIDTH-1:0]          err_count,
    output logic                              err_irq
);

    localparam int         WS_M1    = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] CNT_INIT = WS_M1[3:0];

    err_state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       accept;

    assign accept = ahb.HSEL && ahb.HREADY && trans_active(ahb.HTRANS);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE, ST_ERR2: begin
                // ERR2 already drives HREADYOUT high, so a pipelined accept
                // there starts the next sequence without returning to IDLE.
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else if (RESP_MODE != 0) begin
                        state_nxt = ST_ERR1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = (RESP_MODE != 0) ? ST_ERR1 : ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs depend only on the state flops, never on the bus inputs.
    assign ahb.HREADYOUT = (state != ST_WAIT) && (state != ST_ERR1);
    assign ahb.HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign ahb.HRDATA    = DEFAULT_RDATA;

    rsp_s2_prep_ahbic_err_log #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_err_log (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .accept    (accept),
        .HADDR     (ahb.HADDR),
        .HWRITE    (ahb.HWRITE),
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_write (err_write),
        .err_count (err_count)
    );

    assign err_irq = err_valid;

endmodule

// File: tb/tb_rsp_s2_prep_ahbic_error_slave.sv
// tb/tb_rsp_s2_prep_ahbic_error_slave.sv - multi-configuration bench for the AHB error slave
module tb_rsp_s2_prep_ahbic_error_slave;

    localparam int N        = 5;
    localparam int IDLE_AGE = 1000;

    function automatic int ws_of(int i);
        case (i)
            0: return 0;
            1: return 3;
            2: return 2;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int rm_of(int i);
        return (i == 2 || i == 4) ? 0 : 1;
    endfunction

    function automatic int cw_of(int i);
        case (i)
            3: return 2;
            4: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] rd_of(int i);
        case (i)
            2: return 32'hDEADBEEF;
            4: return 32'h0BAD_F00D;
            default: return 32'h0;
        endcase
    endfunction

    logic        hclk;
    logic        hresetn;
    logic        hsel      [N];
    logic [31:0] haddr     [N];
    logic [1:0]  htrans    [N];
    logic        hwrite    [N];
    logic        hready    [N];
    logic        stall     [N];
    logic        err_clr   [N];
    logic        hreadyout [N];
    logic [1:0]  hresp     [N];
    logic [31:0] hrdata    [N];
    logic        ev        [N];
    logic [31:0] ea        [N];
    logic        ew        [N];
    logic [7:0]  ec        [N];
    logic        irq       [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int CW = cw_of(g);
        logic [CW-1:0] cnt;

        rsp_s2_prep_ahbic_error_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

        assign bus.HSEL   = hsel[g];
        assign bus.HADDR  = haddr[g];
        assign bus.HTRANS = htrans[g];
        assign bus.HWRITE = hwrite[g];
        assign bus.HREADY = hready[g];
        assign hreadyout[g] = bus.HREADYOUT;
        assign hresp[g]     = bus.HRESP;
        assign hrdata[g]    = bus.HRDATA;
        assign ec[g]        = 8'(cnt);

        rsp_s2_prep_ahbic_error_slave #(
            .ADDR_WIDTH    (32),
            .DATA_WIDTH    (32),
            .WAIT_STATES   (ws_of(g)),
            .RESP_MODE     (rm_of(g)),
            .DEFAULT_RDATA (rd_of(g)),
            .ERR_CNT_WIDTH (CW)
        ) u_dut (
            .HCLK      (hclk),
            .HRESETn   (hresetn),
            .ahb       (bus.slave),
            .err_clr   (err_clr[g]),
            .err_valid (ev[g]),
            .err_addr  (ea[g]),
            .err_write (ew[g]),
            .err_count (cnt),
            .err_irq   (irq[g])
        );
    end

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model: "age" is the number of edges since the last accepted
    // fault; the response pattern is a pure function of age and parameters.
    int          age [N];
    bit          mv  [N];
    logic [31:0] ma  [N];
    bit          mw  [N];
    int          mc  [N];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ready(int i);
        if (age[i] >= 1 && age[i] <= ws_of(i)) return 1'b0;
        if (rm_of(i) != 0 && age[i] == ws_of(i) + 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [1:0] exp_resp(int i);
        if (rm_of(i) != 0 && (age[i] == ws_of(i) + 1 || age[i] == ws_of(i) + 2)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic cycle();
        bit acc [N];
        bit rst;
        rst = !hresetn;
        for (int i = 0; i < N; i++) acc[i] = hsel[i] && hready[i] && htrans[i][1];
        @(posedge hclk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                age[i] = IDLE_AGE; mv[i] = 0; ma[i] = 0; mw[i] = 0; mc[i] = 0;
            end else begin
                if (err_clr[i]) begin
                    mv[i] = 0; mc[i] = 0;
                end
                if (acc[i]) begin
                    if (!mv[i]) begin
                        ma[i] = haddr[i]; mw[i] = hwrite[i];
                    end
                    mv[i] = 1;
                    if (mc[i] < (1 << cw_of(i)) - 1) mc[i]++;
                    age[i] = 1;
                end else if (age[i] < IDLE_AGE) begin
                    age[i]++;
                end
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("%0d.hreadyout", i), 64'(hreadyout[i]), 64'(exp_ready(i)));
            check($sformatf("%0d.hresp", i),     64'(hresp[i]),     64'(exp_resp(i)));
            check($sformatf("%0d.hrdata", i),    64'(hrdata[i]),    64'(rd_of(i)));
            check($sformatf("%0d.err_valid", i), 64'(ev[i]),        64'(mv[i]));
            check($sformatf("%0d.err_addr", i),  64'(ea[i]),        64'(ma[i]));
            check($sformatf("%0d.err_write", i), 64'(ew[i]),        64'(mw[i]));
            check($sformatf("%0d.err_count", i), 64'(ec[i]),        64'(mc[i]));
            check($sformatf("%0d.err_irq", i),   64'(irq[i]),       64'(mv[i]));
        end
        for (int i = 0; i < N; i++) hready[i] = exp_ready(i) & ~stall[i];
    endtask

    task automatic set_all(input bit sel, input logic [1:0] tr, input logic [31:0] addr,
                           input bit wr, input bit clr, input bit stl);
        for (int i = 0; i < N; i++) begin
            hsel[i] = sel; htrans[i] = tr; haddr[i] = addr; hwrite[i] = wr;
            err_clr[i] = clr; stall[i] = stl;
            hready[i] = exp_ready(i) & ~stl;
        end
    endtask

    task automatic rand_drive();
        hresetn = ($urandom_range(0, 299) != 0);
        for (int i = 0; i < N; i++) begin
            hsel[i]    = ($urandom_range(0, 3) != 0);
            htrans[i]  = 2'($urandom_range(0, 3));
            haddr[i]   = $urandom & 32'hFFFF_FFFC;
            hwrite[i]  = 1'($urandom_range(0, 1));
            stall[i]   = ($urandom_range(0, 7) == 0);
            err_clr[i] = ($urandom_range(0, 15) == 0);
            hready[i]  = exp_ready(i) & ~stall[i];
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            age[i] = IDLE_AGE; mv[i] = 0; ma[i] = 0; mw[i] = 0; mc[i] = 0;
        end
        hresetn = 1'b0;
        set_all(0, 2'b00, 32'h0, 0, 0, 0);
        repeat (2) cycle();
        check("rst.hreadyout", 64'(hreadyout[0]), 64'd1);
        check("rst.hresp",     64'(hresp[0]),     64'd0);
        check("rst.err_valid", 64'(ev[0]),        64'd0);
        check("rst.err_count", 64'(ec[0]),        64'd0);

        // Single NONSEQ read seen by every configuration.
        hresetn = 1'b1;
        set_all(1, 2'b10, 32'h4000_0010, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k == 1) set_all(1, 2'b00, 32'h0, 0, 0, 0);
            check($sformatf("ws3.hreadyout.%0d", k), 64'(hreadyout[1]), (k < 5) ? 64'd0 : 64'd1);
            check($sformatf("ws3.hresp.%0d", k),     64'(hresp[1]),     (k >= 4) ? 64'd1 : 64'd0);
            check($sformatf("okay.hreadyout.%0d", k), 64'(hreadyout[2]), (k >= 3) ? 64'd1 : 64'd0);
            if (k == 1) begin
                check("ws0.err1.hreadyout", 64'(hreadyout[0]), 64'd0);
                check("ws0.err1.hresp",     64'(hresp[0]),     64'd1);
            end
            if (k == 2) begin
                check("ws0.err2.hreadyout", 64'(hreadyout[0]), 64'd1);
                check("ws0.err2.hresp",     64'(hresp[0]),     64'd1);
                check("ws0.err_valid",      64'(ev[0]),        64'd1);
                check("ws0.err_addr",       64'(ea[0]),        64'h4000_0010);
                check("ws0.err_write",      64'(ew[0]),        64'd0);
                check("ws0.err_count",      64'(ec[0]),        64'd1);
                check("ws0.err_irq",        64'(irq[0]),       64'd1);
            end
            if (k == 3) begin
                check("okay.hresp",     64'(hresp[2]),  64'd0);
                check("okay.hrdata",    64'(hrdata[2]), 64'hDEAD_BEEF);
                check("okay.err_count", 64'(ec[2]),     64'd1);
            end
        end
        repeat (2) cycle();

        // Non-accepted transfers: IDLE, BUSY, NONSEQ with HREADY low.
        set_all(1, 2'b00, 32'h50, 1, 0, 0); cycle();
        set_all(1, 2'b01, 32'h50, 1, 0, 0); cycle();
        set_all(1, 2'b10, 32'h54, 1, 0, 1); cycle();
        check("noacc.hreadyout", 64'(hreadyout[0]), 64'd1);
        check("noacc.hresp",     64'(hresp[0]),     64'd0);
        check("noacc.err_count", 64'(ec[0]),        64'd1);
        check("noacc.ws3.count", 64'(ec[1]),        64'd1);

        // Clear, then back-to-back faults with the second issued in ERR2.
        set_all(1, 2'b00, 32'h0, 0, 1, 0); cycle();
        check("clr.err_valid", 64'(ev[0]), 64'd0);
        check("clr.err_count", 64'(ec[0]), 64'd0);
        set_all(1, 2'b10, 32'h10, 0, 0, 0); cycle();
        set_all(1, 2'b10, 32'h20, 1, 0, 0); cycle(); cycle();
        check("b2b.err1.hreadyout", 64'(hreadyout[0]), 64'd0);
        check("b2b.err1.hresp",     64'(hresp[0]),     64'd1);
        set_all(1, 2'b00, 32'h0, 0, 0, 0); cycle();
        check("b2b.err2.hreadyout", 64'(hreadyout[0]), 64'd1);
        check("b2b.err2.hresp",     64'(hresp[0]),     64'd1);
        check("b2b.err_addr",       64'(ea[0]),        64'h10);
        check("b2b.err_count",      64'(ec[0]),        64'd2);
        repeat (6) cycle();

        // Saturation of a 2-bit counter, then clear coincident with a fault.
        set_all(1, 2'b10, 32'h60, 0, 0, 0); repeat (20) cycle();
        check("sat.err_count", 64'(ec[3]), 64'd3);
        set_all(1, 2'b00, 32'h0, 0, 0, 0); repeat (6) cycle();
        set_all(1, 2'b11, 32'h30, 1, 1, 0); cycle();
        check("clracc.err_count", 64'(ec[3]), 64'd1);
        check("clracc.err_addr",  64'(ea[3]), 64'h30);
        check("clracc.err_valid", 64'(ev[3]), 64'd1);
        check("clracc.err_write", 64'(ew[3]), 64'd1);
        set_all(1, 2'b00, 32'h0, 0, 0, 0); repeat (6) cycle();

        // Reset in the middle of a wait sequence.
        set_all(1, 2'b10, 32'h70, 1, 0, 0); cycle();
        check("rstwait.in_wait", 64'(hreadyout[1]), 64'd0);
        set_all(1, 2'b00, 32'h0, 0, 0, 0);
        hresetn = 1'b0; cycle();
        check("rstwait.hreadyout", 64'(hreadyout[1]), 64'd1);
        check("rstwait.hresp",     64'(hresp[1]),     64'd0);
        check("rstwait.err_valid", 64'(ev[1]),        64'd0);
        check("rstwait.err_addr",  64'(ea[1]),        64'd0);
        check("rstwait.err_write", 64'(ew[1]),        64'd0);
        check("rstwait.err_count", 64'(ec[1]),        64'd0);
        hresetn = 1'b1;

        repeat (3000) begin
            rand_drive();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
